// File: rtl/alu_issue_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_pkg
//   Shared types for the ALU issue stage: the ALU opcode encoding and the
//   payload layouts of the execute (E) and writeback (W) slots.
// -----------------------------------------------------------------------------
package alu_issue_stage_pkg;

   localparam int unsigned ALU_DW  = 32;
   localparam int unsigned ALU_RAW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef struct packed {
      alu_op_t              op;
      logic [ALU_DW-1:0]    a_value;
      logic [ALU_DW-1:0]    b_value;
      logic [ALU_RAW-1:0]   a_addr;
      logic [ALU_RAW-1:0]   b_addr;
      logic                 a_is_reg;
      logic                 b_is_reg;
      logic [ALU_RAW-1:0]   dest;
      logic                 we;
   } exec_slot_t;

   typedef struct packed {
      logic [ALU_DW-1:0]    result;
      logic                 zero;
      logic                 negative;
      logic [ALU_RAW-1:0]   dest;
      logic                 we;
   } wb_slot_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
//   Bundles the three buses of the issue stage:
//     in_*  : decoded op from decode (valid/ready)
//     alu_* / operand_* : combinational ALU request/response
//     wb_*  : writeback slot towards regfile/flags (valid/ready)
//   slave  : the issue stage itself
//   master : the surrounding pipeline (decode, ALU, regfile)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = ALU_DW,
   parameter int unsigned REG_ADDR_WIDTH = ALU_RAW
) ();

   logic                      in_valid;
   logic                      in_ready;
   alu_op_t                   in_alu_op;
   logic [DATA_WIDTH-1:0]     in_a_value;
   logic [DATA_WIDTH-1:0]     in_b_value;
   logic [REG_ADDR_WIDTH-1:0] in_a_addr;
   logic [REG_ADDR_WIDTH-1:0] in_b_addr;
   logic                      in_a_is_reg;
   logic                      in_b_is_reg;
   logic [REG_ADDR_WIDTH-1:0] in_dest_addr;
   logic                      in_write_en;

   alu_op_t                   alu_op;
   logic [DATA_WIDTH-1:0]     operand_a;
   logic [DATA_WIDTH-1:0]     operand_b;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic                      alu_zero;
   logic                      alu_negative;

   logic                      wb_valid;
   logic                      wb_ready;
   logic [REG_ADDR_WIDTH-1:0] wb_dest_addr;
   logic                      wb_write_en;
   logic [DATA_WIDTH-1:0]     wb_result;
   logic                      wb_zero;
   logic                      wb_negative;

   modport slave (
      input  in_valid, in_alu_op, in_a_value, in_b_value, in_a_addr, in_b_addr,
             in_a_is_reg, in_b_is_reg, in_dest_addr, in_write_en,
      output in_ready,
      output alu_op, operand_a, operand_b,
      input  alu_result, alu_zero, alu_negative,
      output wb_valid, wb_dest_addr, wb_write_en, wb_result, wb_zero, wb_negative,
      input  wb_ready
   );

   modport master (
      output in_valid, in_alu_op, in_a_value, in_b_value, in_a_addr, in_b_addr,
             in_a_is_reg, in_b_is_reg, in_dest_addr, in_write_en,
      input  in_ready,
      input  alu_op, operand_a, operand_b,
      output alu_result, alu_zero, alu_negative,
      input  wb_valid, wb_dest_addr, wb_write_en, wb_result, wb_zero, wb_negative,
      output wb_ready
   );

endinterface

// File: rtl/alu_issue_stage_operand_forward.sv
// -----------------------------------------------------------------------------
// operand_forward
//   Per-operand hazard logic for the issue stage (one instance per operand).
//   Ports:
//     e_*_i        : operand fields held in E, plus E's dest/we and move/hold
//     w_*_i        : W slot state and whether it retires this cycle
//     in_*_i       : operand fields presented by decode
//     operand_o    : post-forwarding value driven to the ALU
//     capture_o    : value to store into E when decode's op is accepted
//     patch_o      : E must overwrite its stored value with w_result_i
// -----------------------------------------------------------------------------
module operand_forward
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = ALU_DW,
   parameter int unsigned REG_ADDR_WIDTH = ALU_RAW
) (
   input  logic [DATA_WIDTH-1:0]     e_value_i,
   input  logic [REG_ADDR_WIDTH-1:0] e_addr_i,
   input  logic                      e_is_reg_i,
   input  logic                      e_hold_i,
   input  logic                      e_move_i,
   input  logic [REG_ADDR_WIDTH-1:0] e_dest_i,
   input  logic                      e_we_i,
   input  logic                      w_valid_i,
   input  logic                      w_we_i,
   input  logic [REG_ADDR_WIDTH-1:0] w_dest_i,
   input  logic [DATA_WIDTH-1:0]     w_result_i,
   input  logic                      retire_i,
   input  logic [DATA_WIDTH-1:0]     in_value_i,
   input  logic [REG_ADDR_WIDTH-1:0] in_addr_i,
   input  logic                      in_is_reg_i,
   output logic [DATA_WIDTH-1:0]     operand_o,
   output logic [DATA_WIDTH-1:0]     capture_o,
   output logic                      patch_o
);

   logic fwd_e;
   logic in_fwdable;
   logic pred_hit;
   logic ret_hit;

   // r0 and immediates are never forwarded
   assign fwd_e = e_is_reg_i & w_valid_i & w_we_i & (e_addr_i == w_dest_i)
                & (e_addr_i != '0);

   assign operand_o = fwd_e ? w_result_i : e_value_i;

   assign in_fwdable = in_is_reg_i & (in_addr_i != '0);
   assign pred_hit   = e_move_i & e_we_i & (e_dest_i == in_addr_i) & in_fwdable;
   assign ret_hit    = retire_i & w_we_i & (w_dest_i == in_addr_i) & in_fwdable;

   // The producer moving E->W is younger than the one leaving W, so it wins;
   // its value is picked up by the W forward next cycle, hence keep the raw
   // decode value here.
   always_comb begin
      capture_o = in_value_i;
      if (pred_hit) begin
         capture_o = in_value_i;
      end else if (ret_hit) begin
         capture_o = w_result_i;
      end
   end

   // Keeps a forwarded value alive if W drains while E stays put
   assign patch_o = e_hold_i & retire_i & fwd_e;

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   Execute holding slot (E) and writeback slot (W) around a combinational ALU,
//   with RAW forwarding from W.
//   Ports:
//     clock   : rising-edge clock
//     n_reset : asynchronous active-low reset
//     flush   : synchronous discard of both slots
//     bus     : decode / ALU / writeback signals (alu_issue_stage_if.slave)
//   Latency: accepted at N -> ALU ports at N+1 -> wb_* at N+2; 1 op/cycle.
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = ALU_DW,
   parameter int unsigned REG_ADDR_WIDTH = ALU_RAW
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              flush,
   alu_issue_stage_if.slave  bus
);

   exec_slot_t e_q, e_d;
   wb_slot_t   w_q, w_d;
   logic       e_valid_q, e_valid_d;
   logic       w_valid_q, w_valid_d;

   logic w_free;
   logic e_move;
   logic e_hold;
   logic in_ready;
   logic accept;
   logic retire;

   logic [DATA_WIDTH-1:0] a_capture, b_capture;
   logic                  a_patch, b_patch;

   assign w_free   = !w_valid_q | bus.wb_ready;
   assign e_move   = e_valid_q & w_free;
   assign e_hold   = e_valid_q & !w_free;
   assign in_ready = !e_valid_q | w_free;
   assign accept   = bus.in_valid & in_ready;
   assign retire   = w_valid_q & bus.wb_ready;

   operand_forward #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_a (
      .e_value_i   (e_q.a_value),
      .e_addr_i    (e_q.a_addr),
      .e_is_reg_i  (e_q.a_is_reg),
      .e_hold_i    (e_hold),
      .e_move_i    (e_move),
      .e_dest_i    (e_q.dest),
      .e_we_i      (e_q.we),
      .w_valid_i   (w_valid_q),
      .w_we_i      (w_q.we),
      .w_dest_i    (w_q.dest),
      .w_result_i  (w_q.result),
      .retire_i    (retire),
      .in_value_i  (bus.in_a_value),
      .in_addr_i   (bus.in_a_addr),
      .in_is_reg_i (bus.in_a_is_reg),
      .operand_o   (bus.operand_a),
      .capture_o   (a_capture),
      .patch_o     (a_patch)
   );

   operand_forward #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_b (
      .e_value_i   (e_q.b_value),
      .e_addr_i    (e_q.b_addr),
      .e_is_reg_i  (e_q.b_is_reg),
      .e_hold_i    (e_hold),
      .e_move_i    (e_move),
      .e_dest_i    (e_q.dest),
      .e_we_i      (e_q.we),
      .w_valid_i   (w_valid_q),
      .w_we_i      (w_q.we),
      .w_dest_i    (w_q.dest),
      .w_result_i  (w_q.result),
      .retire_i    (retire),
      .in_value_i  (bus.in_b_value),
      .in_addr_i   (bus.in_b_addr),
      .in_is_reg_i (bus.in_b_is_reg),
      .operand_o   (bus.operand_b),
      .capture_o   (b_capture),
      .patch_o     (b_patch)
   );

   // E slot: flush discards any handshake; payloads only change on a real load
   always_comb begin
      e_valid_d = e_valid_q;
      e_d       = e_q;
      if (flush) begin
         e_valid_d = 1'b0;
      end else if (accept) begin
         e_valid_d  = 1'b1;
         e_d.op       = bus.in_alu_op;
         e_d.a_value  = a_capture;
         e_d.b_value  = b_capture;
         e_d.a_addr   = bus.in_a_addr;
         e_d.b_addr   = bus.in_b_addr;
         e_d.a_is_reg = bus.in_a_is_reg;
         e_d.b_is_reg = bus.in_b_is_reg;
         e_d.dest     = bus.in_dest_addr;
         e_d.we       = bus.in_write_en;
      end else begin
         if (e_move) begin
            e_valid_d = 1'b0;
         end
         if (a_patch) begin
            e_d.a_value = w_q.result;
         end
         if (b_patch) begin
            e_d.b_value = w_q.result;
         end
      end
   end

   // W slot: refill from E takes priority over retire (same-cycle retire+refill)
   always_comb begin
      w_valid_d = w_valid_q;
      w_d       = w_q;
      if (flush) begin
         w_valid_d = 1'b0;
      end else if (e_move) begin
         w_valid_d    = 1'b1;
         w_d.result   = bus.alu_result;
         w_d.zero     = bus.alu_zero;
         w_d.negative = bus.alu_negative;
         w_d.dest     = e_q.dest;
         w_d.we       = e_q.we;
      end else if (retire) begin
         w_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         e_valid_q <= 1'b0;
         w_valid_q <= 1'b0;
         e_q       <= '0;
         w_q       <= '0;
      end else begin
         e_valid_q <= e_valid_d;
         w_valid_q <= w_valid_d;
         e_q       <= e_d;
         w_q       <= w_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.alu_op       = e_q.op;
   assign bus.wb_valid     = w_valid_q;
   assign bus.wb_dest_addr = w_q.dest;
   assign bus.wb_write_en  = w_q.we;
   assign bus.wb_result    = w_q.result;
   assign bus.wb_zero      = w_q.zero;
   assign bus.wb_negative  = w_q.negative;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage with a behavioural ALU, a shadow
//   regfile written on retire (what decode reads, possibly stale) and an
//   architectural model used to compute the expected results.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        neg;
      logic [4:0]  dest;
      logic        we;
   } exp_t;

   logic clock = 1'b0;
   logic n_reset;
   logic flush;

   always #5 clock = ~clock;

   alu_issue_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   alu_issue_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clock   (clock),
      .n_reset (n_reset),
      .flush   (flush),
      .bus     (bus.slave)
   );

   // Behavioural ALU
   logic [31:0] alu_r;
   always_comb begin
      case (bus.alu_op)
         ALU_ADD: alu_r = bus.operand_a + bus.operand_b;
         ALU_SUB: alu_r = bus.operand_a - bus.operand_b;
         ALU_AND: alu_r = bus.operand_a & bus.operand_b;
         ALU_OR:  alu_r = bus.operand_a | bus.operand_b;
         ALU_XOR: alu_r = bus.operand_a ^ bus.operand_b;
         default: alu_r = '0;
      endcase
      bus.alu_result   = alu_r;
      bus.alu_zero     = (alu_r == 32'd0);
      bus.alu_negative = alu_r[31];
   end

   exp_t        sb[$];
   logic [31:0] rf[32];
   logic [31:0] am[32];
   logic [31:0] am_save[32];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Scoreboard: every retire must match the oldest expected result
   exp_t got;
   always @(negedge clock) begin
      if (n_reset === 1'b1 && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
         chk("sb_pending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("sb_result", bus.wb_result, got.result);
            chk("sb_zero", 32'(bus.wb_zero), 32'(got.zero));
            chk("sb_neg", 32'(bus.wb_negative), 32'(got.neg));
            chk("sb_dest", 32'(bus.wb_dest_addr), 32'(got.dest));
            chk("sb_we", 32'(bus.wb_write_en), 32'(got.we));
         end
         if (bus.wb_write_en === 1'b1 && bus.wb_dest_addr != 5'd0)
            rf[bus.wb_dest_addr] = bus.wb_result;
      end
   end

   // a/b: register address when *_reg is set, otherwise the immediate
   task automatic issue(input alu_op_t op, input logic a_reg, input logic [31:0] a,
                        input logic b_reg, input logic [31:0] b, input logic [4:0] dest);
      logic [31:0] ea, eb, r;
      exp_t        x;
      int          n;
      ea = a_reg ? am[a[4:0]] : a;
      eb = b_reg ? am[b[4:0]] : b;
      r  = ref_alu(op, ea, eb);
      if (dest != 5'd0) am[dest] = r;
      x.result = r;
      x.zero   = (r == 32'd0);
      x.neg    = r[31];
      x.dest   = dest;
      x.we     = 1'b1;
      sb.push_back(x);
      bus.in_alu_op    = op;
      bus.in_a_is_reg  = a_reg;
      bus.in_b_is_reg  = b_reg;
      bus.in_a_addr    = a_reg ? a[4:0] : 5'd0;
      bus.in_b_addr    = b_reg ? b[4:0] : 5'd0;
      bus.in_a_value   = a_reg ? rf[a[4:0]] : a;
      bus.in_b_value   = b_reg ? rf[b[4:0]] : b;
      bus.in_dest_addr = dest;
      bus.in_write_en  = 1'b1;
      bus.in_valid     = 1'b1;
      n = 0;
      @(negedge clock);
      while (bus.in_ready !== 1'b1 && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         n++;
         @(posedge clock);
         #1;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      n_reset          = 1'b0;
      flush            = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_alu_op    = ALU_ADD;
      bus.in_a_value   = '0;
      bus.in_b_value   = '0;
      bus.in_a_addr    = '0;
      bus.in_b_addr    = '0;
      bus.in_a_is_reg  = 1'b0;
      bus.in_b_is_reg  = 1'b0;
      bus.in_dest_addr = '0;
      bus.in_write_en  = 1'b0;
      bus.wb_ready     = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rf[i] = '0;
         am[i] = '0;
      end

      // Reset state
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      chk("rst_operand_a", bus.operand_a, 32'd0);
      chk("rst_operand_b", bus.operand_b, 32'd0);
      chk("rst_wb_result", bus.wb_result, 32'd0);
      chk("rst_wb_dest", 32'(bus.wb_dest_addr), 32'd0);
      chk("rst_wb_we", 32'(bus.wb_write_en), 32'd0);
      @(negedge clock);
      n_reset = 1'b1;
      @(posedge clock);
      #1;

      // 1: asynchronous reset mid-stream with W occupied
      am_save = am;
      issue(ALU_ADD, 1'b0, 32'd20, 1'b0, 32'd22, 5'd7);
      begin
         int n;
         n = 0;
         while (bus.wb_valid !== 1'b1 && n < 10) begin
            n++;
            @(negedge clock);
         end
      end
      chk("t1_wb_valid_before", 32'(bus.wb_valid), 32'd1);
      #2;
      n_reset = 1'b0;
      #1;
      chk("t1_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t1_operand_a", bus.operand_a, 32'd0);
      am = am_save;
      sb.delete();
      @(negedge clock);
      n_reset = 1'b1;
      @(posedge clock);
      #1;

      // 2: back-to-back stream, 2-cycle latency
      bus.wb_ready = 1'b1;
      issue(ALU_ADD, 1'b0, 32'd3, 1'b0, 32'd4, 5'd1);
      issue(ALU_ADD, 1'b0, 32'd10, 1'b0, 32'hFFFF_FFF6, 5'd2);
      @(negedge clock);
      chk("t2_first_valid", 32'(bus.wb_valid), 32'd1);
      chk("t2_first_result", bus.wb_result, 32'd7);
      chk("t2_first_zero", 32'(bus.wb_zero), 32'd0);
      @(negedge clock);
      chk("t2_second_valid", 32'(bus.wb_valid), 32'd1);
      chk("t2_second_result", bus.wb_result, 32'd0);
      chk("t2_second_zero", 32'(bus.wb_zero), 32'd1);
      chk("t2_second_neg", 32'(bus.wb_negative), 32'd0);
      drain();

      // 3: RAW forwarding on A and B, and r0 never forwarded
      issue(ALU_ADD, 1'b0, 32'd5, 1'b0, 32'd6, 5'd3);
      issue(ALU_ADD, 1'b1, 32'd3, 1'b0, 32'd1, 5'd4);
      issue(ALU_ADD, 1'b0, 32'd7, 1'b0, 32'd0, 5'd12);
      issue(ALU_SUB, 1'b0, 32'd1, 1'b1, 32'd12, 5'd13);
      drain();
      chk("t3_r4", rf[4], 32'd12);
      chk("t3_r13", rf[13], 32'hFFFF_FFFA);
      issue(ALU_ADD, 1'b0, 32'd5, 1'b0, 32'd6, 5'd0);
      issue(ALU_ADD, 1'b1, 32'd0, 1'b0, 32'd1, 5'd10);
      drain();
      chk("t3_r10", rf[10], 32'd1);

      // 4: stall with dependent op held in E
      bus.wb_ready = 1'b0;
      issue(ALU_ADD, 1'b0, 32'd5, 1'b0, 32'd6, 5'd14);
      issue(ALU_ADD, 1'b1, 32'd14, 1'b0, 32'd1, 5'd15);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
         chk("t4_wb_valid", 32'(bus.wb_valid), 32'd1);
         chk("t4_wb_result", bus.wb_result, 32'd11);
         chk("t4_wb_dest", 32'(bus.wb_dest_addr), 32'd14);
         chk("t4_operand_a", bus.operand_a, 32'd11);
      end
      @(posedge clock);
      #1;
      bus.wb_ready = 1'b1;
      drain();
      chk("t4_r15", rf[15], 32'd12);

      // 5: W retires in the cycle decode issues a stale read of its dest
      issue(ALU_ADD, 1'b0, 32'd1, 1'b0, 32'd1, 5'd5);
      drain();
      issue(ALU_ADD, 1'b0, 32'd4, 1'b0, 32'd5, 5'd5);
      @(posedge clock);
      #1;
      issue(ALU_ADD, 1'b1, 32'd5, 1'b0, 32'd1, 5'd16);
      drain();
      chk("t5_r16", rf[16], 32'd10);

      // 6: flush with both slots full and an op presented
      bus.wb_ready = 1'b0;
      am_save = am;
      issue(ALU_ADD, 1'b0, 32'd1, 1'b0, 32'd2, 5'd17);
      issue(ALU_ADD, 1'b0, 32'd3, 1'b0, 32'd4, 5'd18);
      bus.in_alu_op    = ALU_ADD;
      bus.in_a_is_reg  = 1'b0;
      bus.in_b_is_reg  = 1'b0;
      bus.in_a_value   = 32'd50;
      bus.in_b_value   = 32'd50;
      bus.in_dest_addr = 5'd19;
      bus.in_write_en  = 1'b1;
      bus.in_valid     = 1'b1;
      flush            = 1'b1;
      @(negedge clock);
      chk("t6_full_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("t6_full_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      am = am_save;
      @(negedge clock);
      chk("t6_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clock);
      #1;
      bus.wb_ready = 1'b1;
      // an accepted handshake in the flush cycle is discarded too
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("t6_quiet", 32'(bus.wb_valid), 32'd0);
      end
      @(posedge clock);
      #1;

      // Stage still works after flush
      issue(ALU_ADD, 1'b0, 32'd2, 1'b0, 32'd2, 5'd19);
      drain();
      chk("post_r19", rf[19], 32'd4);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
